mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter_lat.sv | 31 +++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: FSM encodings and latency bounds.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_t;

  // Legal LATENCY range; the counter width is sized to hold LAT_MAX.
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 7;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

endpackage

// File: rtl/mem_arbiter_lat.sv
// Latency down-counter: loaded with LATENCY at acceptance, counts to zero.
module lat_counter
  import mem_arbiter_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  logic [CNT_W-1:0] count_reg;

  // Load on acceptance, then decrement once per busy cycle, saturating at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= CNT_W'(LATENCY);
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign count = count_reg;
  assign done  = (count_reg == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between instruction fetch and data stage for a single-port RAM.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              if_stall,
  output logic              mem_stall,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  arb_state_t       state_reg, state_next;
  logic             last_data_reg;
  logic             we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;

  logic             accept;
  logic             pick_data;
  logic             busy;
  logic             cnt_done;
  logic             issue;
  logic [CNT_W-1:0] cnt;

  assign busy   = (state_reg != ST_IDLE);
  assign accept = (state_reg == ST_IDLE) && (if_req || mem_req);
  // Data wins contention unless it took the previous grant.
  assign pick_data = mem_req && (!if_req || !last_data_reg);

  lat_counter #(
    .LATENCY(LATENCY)
  ) u_lat (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .en   (busy),
    .count(cnt),
    .done (cnt_done)
  );

  // The counter still holds LATENCY only in the first busy cycle.
  assign issue = busy && (cnt == CNT_W'(LATENCY));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, return to IDLE after the ready cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = pick_data ? ST_BUSY_D : ST_BUSY_I;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (cnt_done) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Capture the winning command at acceptance; held for the whole busy period.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg      <= '0;
      wdata_reg     <= '0;
      we_reg        <= 1'b0;
      last_data_reg <= 1'b0;
    end else if (accept) begin
      addr_reg      <= pick_data ? mem_addr : if_addr;
      wdata_reg     <= pick_data ? mem_wdata : '0;
      we_reg        <= pick_data && mem_we;
      last_data_reg <= pick_data;
    end
  end

  // Output decode; everything except stalls is forced low while rst is high.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if_ready  = 1'b0;
    mem_ready = 1'b0;
    if (!rst) begin
      ram_en    = issue;
      ram_we    = issue && we_reg;
      ram_addr  = addr_reg;
      ram_wdata = wdata_reg;
      if_ready  = (state_reg == ST_BUSY_I) && cnt_done;
      mem_ready = (state_reg == ST_BUSY_D) && cnt_done;
    end
  end

  assign if_rdata  = if_ready  ? ram_rdata : '0;
  assign mem_rdata = mem_ready ? ram_rdata : '0;
  assign if_stall  = if_req  && !if_ready;
  assign mem_stall = mem_req && !mem_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with LATENCY=2.
module tb_mem_arbiter;

  localparam logic [31:0] K = 32'h5A5A_0000;

  typedef struct {
    bit          is_data;
    int          cyc;
    bit          chk_data;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        if_stall;
  logic        mem_stall;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   c;
  exp_t sb[$];
  exp_t e;

  mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .LATENCY(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ready (if_ready),
    .if_rdata (if_rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .if_stall (if_stall),
    .mem_stall(mem_stall),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // RAM stand-in: read data is a fixed function of the presented address.
  assign ram_rdata = ram_addr ^ K;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input bit d, input int cy, input bit cd, input logic [31:0] dat);
    exp_t n;
    n.is_data  = d;
    n.cyc      = cy;
    n.chk_data = cd;
    n.data     = dat;
    sb.push_back(n);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    chk("drain_empty", sb.size(), 0);
    step();
    step();
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    step();
    @(negedge clk);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    step();
    rst = 1'b0;
  endtask

  // Completion monitor: each ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    chk("both_ready", if_ready & mem_ready, 0);
    if (if_ready) begin
      chk("if_sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        $display("txn IF  cyc=%0d rdata=%08h", cyc, if_rdata);
        chk("if_kind", e.is_data, 0);
        chk("if_cyc", cyc, e.cyc);
        chk("if_rdata", if_rdata, e.data);
      end
    end else begin
      chk("if_rdata_idle", if_rdata, 0);
    end
    if (mem_ready) begin
      chk("mem_sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        $display("txn MEM cyc=%0d rdata=%08h", cyc, mem_rdata);
        chk("mem_kind", e.is_data, 1);
        chk("mem_cyc", cyc, e.cyc);
        if (e.chk_data) chk("mem_rdata", mem_rdata, e.data);
      end
    end else begin
      chk("mem_rdata_idle", mem_rdata, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    do_reset();

    // Lone IF read.
    step();
    if_req = 1'b1; if_addr = 32'h40; c = cyc;
    push(0, c + 3, 1, 32'h40 ^ K);
    @(negedge clk);
    chk("s1_stall0", if_stall, 1);
    chk("s1_en0", ram_en, 0);
    wait_to(c + 1); @(negedge clk);
    chk("s1_en1", ram_en, 1);
    chk("s1_addr1", ram_addr, 32'h40);
    chk("s1_we1", ram_we, 0);
    chk("s1_stall1", if_stall, 1);
    wait_to(c + 2); @(negedge clk);
    chk("s1_en2", ram_en, 0);
    chk("s1_stall2", if_stall, 1);
    wait_to(c + 3); @(negedge clk);
    chk("s1_stall3", if_stall, 0);
    wait_to(c + 4);
    if_req = 1'b0;
    drain();

    // Contention after reset: data first, then IF.
    do_reset();
    step();
    if_req = 1'b1; if_addr = 32'h80;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200; c = cyc;
    push(1, c + 3, 1, 32'h200 ^ K);
    push(0, c + 7, 1, 32'h80 ^ K);
    wait_to(c + 3); @(negedge clk);
    chk("s2_mem_stall3", mem_stall, 0);
    chk("s2_if_stall3", if_stall, 1);
    wait_to(c + 4);
    mem_req = 1'b0;
    @(negedge clk);
    chk("s2_en4", ram_en, 0);
    wait_to(c + 5); @(negedge clk);
    chk("s2_en5", ram_en, 1);
    chk("s2_addr5", ram_addr, 32'h80);
    wait_to(c + 8);
    if_req = 1'b0;
    drain();

    // Both held 20 cycles: D,I,D,I,D every 4 cycles.
    do_reset();
    step();
    if_req = 1'b1; if_addr = 32'h300;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h400; c = cyc;
    for (int k = 0; k < 5; k++) begin
      if (k % 2 == 0) push(1, c + 3 + 4 * k, 1, 32'h400 ^ K);
      else            push(0, c + 3 + 4 * k, 1, 32'h300 ^ K);
    end
    wait_to(c + 20);
    if_req = 1'b0; mem_req = 1'b0;
    drain();

    // Data write.
    do_reset();
    step();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hDEADBEEF; c = cyc;
    push(1, c + 3, 0, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      wait_to(c + k); @(negedge clk);
      chk("s4_we", ram_we, (k == 1) ? 1 : 0);
      chk("s4_addr", ram_addr, 32'h100);
      chk("s4_wdata", ram_wdata, 32'hDEADBEEF);
    end
    wait_to(c + 4);
    mem_req = 1'b0; mem_we = 1'b0;
    drain();

    // Reset during an IF read: no ready, RAM outputs cleared.
    do_reset();
    step();
    if_req = 1'b1; if_addr = 32'h44; c = cyc;
    wait_to(c + 2);
    rst = 1'b1;
    @(negedge clk);
    chk("s5_rst_addr", ram_addr, 0);
    chk("s5_rst_ready", if_ready, 0);
    wait_to(c + 3);
    rst = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("s5_en", ram_en, 0);
    chk("s5_we", ram_we, 0);
    chk("s5_addr", ram_addr, 0);
    chk("s5_wdata", ram_wdata, 0);
    chk("s5_ready", if_ready, 0);
    drain();

    // Reset during a data read, then contention: data must still win.
    step();
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h44; c = cyc;
    wait_to(c + 2);
    rst = 1'b1;
    wait_to(c + 3);
    rst = 1'b0; mem_req = 1'b0;
    wait_to(c + 4);
    if_req = 1'b1; if_addr = 32'h48;
    mem_req = 1'b1; mem_addr = 32'h500;
    push(1, c + 7, 1, 32'h500 ^ K);
    push(0, c + 11, 1, 32'h48 ^ K);
    wait_to(c + 8);
    mem_req = 1'b0;
    wait_to(c + 12);
    if_req = 1'b0;
    drain();

    // IF request dropped mid-access; a data request raised while busy waits for IDLE.
    do_reset();
    step();
    if_req = 1'b1; if_addr = 32'h60; c = cyc;
    push(0, c + 3, 1, 32'h60 ^ K);
    wait_to(c + 1);
    if_req = 1'b0;
    wait_to(c + 2);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h600;
    push(1, c + 7, 1, 32'h600 ^ K);
    wait_to(c + 3); @(negedge clk);
    chk("s6_en3", ram_en, 0);
    wait_to(c + 4); @(negedge clk);
    chk("s6_en4", ram_en, 0);
    wait_to(c + 5); @(negedge clk);
    chk("s6_en5", ram_en, 1);
    chk("s6_addr5", ram_addr, 32'h600);
    wait_to(c + 8);
    mem_req = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
